// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: START-triggered dice roll with fast/decelerating animation and pip decode
`timescale 1ns/1ps
module dice_roll_ctrl #(
  parameter int FAST_DIV   = 2500000,
  parameter int FAST_STEPS = 20,
  parameter int SLOW_STEPS = 5,
  parameter int CNT_W      = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic [6:0] LED,
  output logic [2:0] FACE,
  output logic       BUSY,
  output logic       DONE
);
  localparam int SW = $clog2(FAST_STEPS + 16);
  localparam int LW = $clog2(SLOW_STEPS + 1);
  typedef enum logic [1:0] {IDLE, ROLL, SLOW} state_t;
  state_t state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] tick_q, tick_d, intv_q, intv_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [LW-1:0] slow_q, slow_d;
  logic [2:0] face_q, face_d, face_nx;
  logic [6:0] led_q, led_d;
  logic done_q, done_d;
  logic tick;
  function automatic logic [6:0] pips(input logic [2:0] f);
    case (f)
      3'd1:    return 7'b0001000;
      3'd2:    return 7'b1000001;
      3'd3:    return 7'b1001001;
      3'd4:    return 7'b1010101;
      3'd5:    return 7'b1011101;
      3'd6:    return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction
  // next-state: free-running LFSR, interval countdown, face advance on each tick
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    state_d = state_q;
    tick_d  = tick_q;
    intv_d  = intv_q;
    steps_d = steps_q;
    slow_d  = slow_q;
    face_d  = face_q;
    led_d   = led_q;
    done_d  = 1'b0;
    tick    = tick_q == '0;
    face_nx = face_q == 3'd6 ? 3'd1 : face_q + 3'd1;
    case (state_q)
      IDLE: if (START) begin
        state_d = ROLL;
        tick_d  = CNT_W'(FAST_DIV - 1);
        steps_d = SW'(FAST_STEPS) + SW'(lfsr_q[3:0]);
        intv_d  = CNT_W'(FAST_DIV);
      end
      ROLL: if (!tick) tick_d = tick_q - 1'b1;
      else begin
        face_d  = face_nx;
        led_d   = pips(face_nx);
        steps_d = steps_q - 1'b1;
        tick_d  = intv_q - 1'b1;
        if (steps_q == SW'(1)) begin
          state_d = SLOW;
          intv_d  = CNT_W'(2 * FAST_DIV);
          tick_d  = CNT_W'(2 * FAST_DIV - 1);
          slow_d  = LW'(SLOW_STEPS);
        end
      end
      SLOW: if (!tick) tick_d = tick_q - 1'b1;
      else begin
        face_d = face_nx;
        led_d  = pips(face_nx);
        intv_d = {intv_q[CNT_W-2:0], 1'b0};
        tick_d = {intv_q[CNT_W-2:0], 1'b0} - 1'b1;
        slow_d = slow_q - 1'b1;
        if (slow_q == LW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any roll and blanks the display
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      lfsr_q  <= 8'h01;
      tick_q  <= '0;
      intv_q  <= '0;
      steps_q <= '0;
      slow_q  <= '0;
      face_q  <= 3'd1;
      led_q   <= 7'b0000000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      intv_q  <= intv_d;
      steps_q <= steps_d;
      slow_q  <= slow_d;
      face_q  <= face_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end
  assign LED  = led_q;
  assign FACE = face_q;
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb_dice_roll_ctrl: directed checks of roll timing, reset abort, START handling and pip decode
`timescale 1ns/1ps
module tb_dice_roll_ctrl;
  localparam int FD = 4, FS = 2, SS = 2;
  localparam int SLOW_CYC = FD * ((1 << (SS + 1)) - 2);
  logic CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [6:0] LED;
  logic [2:0] FACE;
  logic BUSY, DONE;
  int checks = 0, failures = 0;
  dice_roll_ctrl #(.FAST_DIV(FD), .FAST_STEPS(FS), .SLOW_STEPS(SS), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LED(LED), .FACE(FACE), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
  function automatic logic [6:0] pips(input int f);
    case (f)
      1: return 7'b0001000;
      2: return 7'b1000001;
      3: return 7'b1001001;
      4: return 7'b1010101;
      5: return 7'b1011101;
      6: return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction
  task automatic do_reset();
    START = 1'b0;
    RST = 1'b0;
    cyc(2);
    RST = 1'b1;
  endtask
  // one roll started on the first edge after reset release (extra = 1)
  task automatic std_roll(input string p, input bit pulses);
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk({p, "_busy_k"}, BUSY, 1);
    chk({p, "_face_k"}, FACE, 1);
    cyc(3);
    chk({p, "_face_k3"}, FACE, 1);
    cyc(1);
    chk({p, "_face_k4"}, FACE, 2);
    chk({p, "_led_k4"}, LED, 7'b1000001);
    if (pulses) begin
      START = 1'b1;
      cyc(1);
      START = 1'b0;
      cyc(3);
    end else cyc(4);
    chk({p, "_face_k8"}, FACE, 3);
    cyc(4);
    chk({p, "_face_k12"}, FACE, 4);
    cyc(8);
    chk({p, "_face_k20"}, FACE, 5);
    if (pulses) begin
      START = 1'b1;
      cyc(1);
      START = 1'b0;
      cyc(14);
    end else cyc(15);
    chk({p, "_face_k35"}, FACE, 5);
    chk({p, "_busy_k35"}, BUSY, 1);
    chk({p, "_done_k35"}, DONE, 0);
    cyc(1);
    chk({p, "_face_k36"}, FACE, 6);
    chk({p, "_busy_k36"}, BUSY, 0);
    chk({p, "_done_k36"}, DONE, 1);
    chk({p, "_led_k36"}, LED, 7'b1110111);
    cyc(1);
    chk({p, "_done_k37"}, DONE, 0);
    cyc(5);
    chk({p, "_idle_busy"}, BUSY, 0);
    chk({p, "_idle_face"}, FACE, 6);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] l;
    int e, d, n, f;
    bit ok_range, ok_led;
    #2 RST = 1'b0;
    #1;
    chk("rst_led", LED, 0);
    chk("rst_face", FACE, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    cyc(3);
    chk("rst_hold_face", FACE, 1);
    RST = 1'b1;
    std_roll("s2", 1'b0);
    do_reset();
    std_roll("s3", 1'b1);
    do_reset();
    START = 1'b1;
    cyc(1);
    cyc(35);
    chk("s4_done_k35", DONE, 0);
    cyc(1);
    chk("s4_done_k36", DONE, 1);
    chk("s4_face_k36", FACE, 6);
    chk("s4_busy_k36", BUSY, 0);
    l = 8'h01;
    repeat (37) l = lstep(l);
    e = int'(l[3:0]);
    d = (FS + e) * FD + SLOW_CYC;
    cyc(1);
    chk("s4_busy_r2", BUSY, 1);
    chk("s4_done_r2", DONE, 0);
    cyc(d - 1);
    chk("s4_done_r2_pre", DONE, 0);
    cyc(1);
    chk("s4_done_r2_end", DONE, 1);
    chk("s4_busy_r2_end", BUSY, 0);
    chk("s4_face_r2_end", FACE, ((5 + FS + e + SS) % 6) + 1);
    cyc(1);
    chk("s4_busy_r3", BUSY, 1);
    chk("s4_done_r3", DONE, 0);
    START = 1'b0;
    do_reset();
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    cyc(15);
    chk("s5_busy_k15", BUSY, 1);
    chk("s5_face_k15", FACE, 4);
    #1 RST = 1'b0;
    #1;
    chk("s5_async_led", LED, 0);
    chk("s5_async_face", FACE, 1);
    chk("s5_async_busy", BUSY, 0);
    chk("s5_async_done", DONE, 0);
    cyc(2);
    chk("s5_hold_done", DONE, 0);
    RST = 1'b1;
    std_roll("s5", 1'b0);
    for (int j = 0; j < 16; j++) begin
      do_reset();
      l = 8'h01;
      repeat (j) l = lstep(l);
      cyc(j);
      START = 1'b1;
      cyc(1);
      START = 1'b0;
      e = int'(l[3:0]);
      d = (FS + e) * FD + SLOW_CYC;
      n = 0;
      ok_range = 1'b1;
      ok_led = 1'b1;
      while (DONE !== 1'b1 && n < 400) begin
        cyc(1);
        n++;
        f = int'(FACE);
        if (f < 1 || f > 6) ok_range = 1'b0;
        if (!(LED === pips(f) || (n < FD && LED === 7'b0))) ok_led = 1'b0;
      end
      chk($sformatf("s6_dur_%0d", j), n, d);
      chk($sformatf("s6_face_%0d", j), FACE, ((FS + e + SS) % 6) + 1);
      chk($sformatf("s6_range_%0d", j), ok_range, 1);
      chk($sformatf("s6_led_%0d", j), ok_led, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
